airlock_chamber: RTL

Chamber-side responder for the airlock interlock. It accepts fill/pressurize and evacuate commands from the interlock controller over a valid/ready handshake and runs each operation as a timed countdown. It enforces the port interlock: commands are refused while either port is open, and the operation stops if a port opens mid-run. It reports chamber state, completion and refusal pulses, and remaining time back to the controller.

---
 rtl/airlock_pkg.sv | 62 ++++++
 rtl/airlock_chamber_tick_prescaler.sv | 31 +++
 rtl/airlock_chamber.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/airlock_pkg.sv
// Shared types and constants for the airlock chamber: state and command
// encodings plus the active-low seven-segment digit table.
package airlock_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY      = 3'd0,
    ST_FILLING    = 3'd1,
    ST_FULL       = 3'd2,
    ST_EVACUATING = 3'd3,
    ST_FAULT      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_FILL  = 2'b01,
    OP_EVAC  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/airlock_chamber_tick_prescaler.sv
// Tick prescaler: one-cycle tick every TICK_DIV enabled cycles; holds at
// zero while disabled and restarts its count on demand.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] cnt;

  assign tick = enable && !restart && (cnt == PW'(TICK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || !enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/airlock_chamber.sv
// Chamber-side airlock responder: timed fill/evacuate operations with port
// interlock. Optional seven-segment readout enabled by AIRLOCK_HEX_EN.
module airlock_chamber
  import airlock_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int FILL_TICKS = 5,
  parameter int EVAC_TICKS = 7,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic             abort,
  input  logic             outer_closed,
  input  logic             inner_closed,
  output logic [2:0]       state,
  output logic             pressurized,
  output logic             evacuated,
  output logic             busy,
  output logic             fault,
  output logic             done,
  output logic             err,
`ifdef AIRLOCK_HEX_EN
  output logic [6:0]       hex_ticks,
`endif
  output logic [CNT_W-1:0] ticks_left
);

  localparam logic [CNT_W-1:0] FILL_LOAD = CNT_W'(FILL_TICKS);
  localparam logic [CNT_W-1:0] EVAC_LOAD = CNT_W'(EVAC_TICKS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ticks_q, ticks_d;
  logic             done_d, err_d;
  logic             ready_q;
  logic             busy_q;
  logic             restart;
  logic             tick;
  logic             ports_ok;
  logic             accept;
  logic             is_move;

  assign ports_ok = outer_closed && inner_closed;
  assign accept   = cmd_valid && ready_q;
  assign is_move  = (cmd_op == OP_FILL) || (cmd_op == OP_EVAC);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (busy_q),
    .restart (restart),
    .tick    (tick)
  );

  // NOTE: every output of this block gets a default before any branch so no
  // path leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    ticks_d = ticks_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    restart = 1'b0;
    case (state_q)
      ST_FILLING: begin
        if (!ports_ok) begin
          state_d = ST_FAULT;
          ticks_d = '0;
        end else if (abort) begin
          restart = 1'b1;
          if (ticks_q == FILL_LOAD) begin
            state_d = ST_EMPTY;
            ticks_d = '0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_EVACUATING;
            ticks_d = FILL_LOAD - ticks_q;
          end
        end else if (tick) begin
          ticks_d = ticks_q - 1'b1;
          if (ticks_q == CNT_W'(1)) begin
            state_d = ST_FULL;
            done_d  = 1'b1;
          end
        end
      end
      ST_EVACUATING: begin
        if (!ports_ok) begin
          state_d = ST_FAULT;
          ticks_d = '0;
        end else if (tick) begin
          ticks_d = ticks_q - 1'b1;
          if (ticks_q == CNT_W'(1)) begin
            state_d = ST_EMPTY;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        // Idle states: EMPTY, FULL, FAULT accept commands in priority order.
        if (accept && (cmd_op != OP_NOP)) begin
          if (is_move && !ports_ok) begin
            err_d = 1'b1;
          end else if ((cmd_op == OP_FILL) && (state_q == ST_EMPTY)) begin
            state_d = ST_FILLING;
            ticks_d = FILL_LOAD;
            restart = 1'b1;
          end else if ((cmd_op == OP_EVAC) && (state_q == ST_FULL)) begin
            state_d = ST_EVACUATING;
            ticks_d = EVAC_LOAD;
            restart = 1'b1;
          end else if (((cmd_op == OP_FILL) && (state_q == ST_FULL)) ||
                       ((cmd_op == OP_EVAC) && (state_q == ST_EMPTY))) begin
            done_d = 1'b1;
          end else if (is_move && (state_q == ST_FAULT)) begin
            err_d = 1'b1;
          end else if ((cmd_op == OP_CLEAR) && (state_q == ST_FAULT)) begin
            if (ports_ok) begin
              state_d = ST_EVACUATING;
              ticks_d = EVAC_LOAD;
              restart = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  // Decodes are registered from the next state so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      ticks_q     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      pressurized <= 1'b0;
      evacuated   <= 1'b1;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ticks_q     <= ticks_d;
      done        <= done_d;
      err         <= err_d;
      ready_q     <= (state_d == ST_EMPTY) || (state_d == ST_FULL) ||
                     (state_d == ST_FAULT);
      busy_q      <= (state_d == ST_FILLING) || (state_d == ST_EVACUATING);
      pressurized <= (state_d == ST_FULL);
      evacuated   <= (state_d == ST_EMPTY);
      fault       <= (state_d == ST_FAULT);
    end
  end

  assign state      = state_q;
  assign ticks_left = ticks_q;
  assign cmd_ready  = ready_q;
  assign busy       = busy_q;

`ifdef AIRLOCK_HEX_EN
  logic       busy_d;
  logic [3:0] digit_d;

  assign busy_d  = (state_d == ST_FILLING) || (state_d == ST_EVACUATING);
  assign digit_d = 4'(ticks_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_ticks <= SEG_BLANK;
    end else begin
      hex_ticks <= busy_d ? seg_encode(digit_d) : SEG_BLANK;
    end
  end
`endif

endmodule
